// File: rtl/sbox_sched_pkg.sv
// Shared types and constants for the S-box ROM sequencer.
package sbox_sched_pkg;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Which requester owns the job currently in flight.
    typedef enum logic {
        OWN_ST = 1'b0,
        OWN_KW = 1'b1
    } owner_e;

    // Byte counters are 5 bits so that a count of 16 is representable.
    localparam int CNT_W = 5;
    // Byte index carried down the return pipeline (0..15).
    localparam int IDX_W = 4;

    localparam logic [CNT_W-1:0] LEN_ST = 5'd16;
    localparam logic [CNT_W-1:0] LEN_KW = 5'd4;

    // Job length in bytes for a given owner.
    function automatic logic [CNT_W-1:0] job_len(input owner_e own);
        return (own == OWN_ST) ? LEN_ST : LEN_KW;
    endfunction

endpackage

// File: rtl/mod_lat_pipe.sv
// Return-tracking shift register: follows each ROM read for LAT cycles so the
// returning byte can be written back to the index it was read from.
module mod_lat_pipe #(
    parameter int LAT   = 1,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    input  logic [IDX_W-1:0] in_idx,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx
);

    logic [LAT-1:0]            valid_q, valid_d;
    logic [LAT-1:0][IDX_W-1:0] idx_q, idx_d;

    // Shift every stage one slot towards the output; stage 0 takes the new read.
    always_comb begin
        valid_d    = '0;
        idx_d      = '0;
        valid_d[0] = in_valid;
        idx_d[0]   = in_idx;
        for (int i = 1; i < LAT; i++) begin
            valid_d[i] = valid_q[i-1];
            idx_d[i]   = idx_q[i-1];
        end
    end

    // Stage registers; clearing the valids drops any read still in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= '0;
            idx_q   <= '0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
        end
    end

    assign out_valid = valid_q[LAT-1];
    assign out_idx   = idx_q[LAT-1];

endmodule

// File: rtl/mod_sbox_sched.sv
// Arbiter and byte sequencer for the shared S-box ROM. Accepts 16-byte state
// jobs and 4-byte key-word jobs, streams each byte to the ROM, reassembles the
// substituted bytes in place and holds the result until acknowledged.
// ROM_LAT must lie in 1..4.
module mod_sbox_sched
    import sbox_sched_pkg::*;
#(
    parameter int ROM_LAT = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             st_valid,
    output logic             st_ready,
    input  logic [15:0][7:0] st_data,
    input  logic             kw_valid,
    output logic             kw_ready,
    input  logic [3:0][7:0]  kw_data,
    output logic             rom_req,
    output logic [7:0]       rom_addr,
    input  logic [7:0]       rom_data,
    output logic             st_res_valid,
    input  logic             st_res_ready,
    output logic             kw_res_valid,
    input  logic             kw_res_ready,
    output logic [15:0][7:0] res_data,
    output logic             busy
);

    state_e           state_q, state_d;
    owner_e           owner_q, owner_d;
    owner_e           last_grant_q, last_grant_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] n_iss_q, n_iss_d;
    logic [CNT_W-1:0] n_ret_q, n_ret_d;
    logic [15:0][7:0] buf_q, buf_d;

    logic             grant_st;
    logic             grant_kw;
    logic             issue_en;
    logic             owner_ack;
    logic             ret_valid;
    logic [IDX_W-1:0] ret_idx;

    // Arbiter: a lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        grant_st = st_valid && (!kw_valid || (last_grant_q == OWN_KW));
        grant_kw = kw_valid && (!st_valid || (last_grant_q == OWN_ST));
    end

    assign issue_en  = (state_q == ISSUE);
    assign owner_ack = (owner_q == OWN_ST) ? st_res_ready : kw_res_ready;

    mod_lat_pipe #(
        .LAT   (ROM_LAT),
        .IDX_W (IDX_W)
    ) u_lat_pipe (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (issue_en),
        .in_idx    (n_iss_q[IDX_W-1:0]),
        .out_valid (ret_valid),
        .out_idx   (ret_idx)
    );

    // Next-state logic: job accept, byte issue, return write-back and release.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        len_d        = len_q;
        n_iss_d      = n_iss_q;
        n_ret_d      = n_ret_q;
        buf_d        = buf_q;
        st_ready     = 1'b0;
        kw_ready     = 1'b0;

        // Returning bytes overwrite their source byte. Returns always lag the
        // issue pointer, so the byte being read this cycle is never clobbered.
        if (ret_valid) begin
            buf_d[ret_idx] = rom_data;
            n_ret_d        = n_ret_q + 5'd1;
        end

        case (state_q)
            IDLE: begin
                if (grant_st) begin
                    st_ready     = 1'b1;
                    buf_d        = st_data;
                    owner_d      = OWN_ST;
                    len_d        = job_len(OWN_ST);
                    last_grant_d = OWN_ST;
                    n_iss_d      = '0;
                    n_ret_d      = '0;
                    state_d      = ISSUE;
                end else if (grant_kw) begin
                    kw_ready     = 1'b1;
                    buf_d        = '0;
                    buf_d[3:0]   = kw_data;
                    owner_d      = OWN_KW;
                    len_d        = job_len(OWN_KW);
                    last_grant_d = OWN_KW;
                    n_iss_d      = '0;
                    n_ret_d      = '0;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                n_iss_d = n_iss_q + 5'd1;
                if (n_iss_q == (len_q - 5'd1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Use the updated count so DONE starts right after the last capture.
                if (n_ret_d == len_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (owner_ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and buffer registers; reset abandons any job in progress.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            owner_q      <= OWN_ST;
            last_grant_q <= OWN_KW;
            len_q        <= '0;
            n_iss_q      <= '0;
            n_ret_q      <= '0;
            buf_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            len_q        <= len_d;
            n_iss_q      <= n_iss_d;
            n_ret_q      <= n_ret_d;
            buf_q        <= buf_d;
        end
    end

    // Registered-state outputs: ROM strobe, result handshakes and status.
    always_comb begin
        rom_req      = issue_en;
        rom_addr     = issue_en ? buf_q[n_iss_q[IDX_W-1:0]] : 8'h00;
        st_res_valid = (state_q == DONE) && (owner_q == OWN_ST);
        kw_res_valid = (state_q == DONE) && (owner_q == OWN_KW);
        res_data     = buf_q;
        busy         = (state_q != IDLE);
    end

endmodule
